// File: rtl/fp32_addsub_arbiter_pkg.sv
// Shared FP32 definitions for the arithmetic-unit sharers: field positions,
// handy constants, the default adder latency and the in-flight tag record.
package fp32_pkg;

  localparam int FP32_W              = 32;
  localparam int FP32_SIGN_BIT       = 31;
  localparam int ADD_LATENCY_DEFAULT = 11;

  // Tag id is sized for the largest supported requester count (8).
  localparam int TAG_ID_W = 3;

  localparam logic [FP32_W-1:0] FP32_ONE = 32'h3F80_0000;
  localparam logic [FP32_W-1:0] FP32_TWO = 32'h4000_0000;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  // Turns an add into a subtract by flipping the sign of the second operand.
  function automatic logic [FP32_W-1:0] flip_sign(input logic [FP32_W-1:0] x, input logic sub);
    return {x[FP32_SIGN_BIT] ^ sub, x[FP32_SIGN_BIT-1:0]};
  endfunction

endpackage

// File: rtl/fp32_addsub_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer (with wrap); the pointer moves past the winner only when a grant
// is actually made, so a stalled cycle keeps the rotation where it was.
module rr_arbiter
  import fp32_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id
);

  localparam int CW = ID_W + 1;

  logic [ID_W-1:0] ptr_reg;
  logic [ID_W-1:0] cand_id [NUM_REQ];

  // cand_id[k] is the requester examined k-th, i.e. (ptr + k) mod NUM_REQ.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [CW-1:0] sum_w;
      logic [CW-1:0] wrap_w;
      assign sum_w        = {1'b0, ptr_reg} + CW'(gi);
      assign wrap_w       = sum_w - CW'(NUM_REQ);
      assign cand_id[gi]  = (sum_w >= CW'(NUM_REQ)) ? wrap_w[ID_W-1:0] : sum_w[ID_W-1:0];
      assign grant[gi]    = grant_valid && (grant_id == ID_W'(gi));
    end
  endgenerate

  // Priority search: scanning from the far end down lets the nearest candidate win.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[cand_id[k]]) begin
        grant_valid = 1'b1;
        grant_id    = cand_id[k];
      end
    end
    if (!en) begin
      grant_valid = 1'b0;
      grant_id    = '0;
    end
  end

  // Pointer advances to the requester after the winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else if (grant_valid) begin
      ptr_reg <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/fp32_addsub_arbiter.sv
// Shares one fixed-latency FP32 add/sub pipeline between NUM_REQ requesters.
// A round-robin grant issues one op per cycle through a register stage; a tag
// shift register of the adder's depth remembers who owns each result. After
// reset a drain window of ADD_LATENCY cycles flushes whatever the adder still
// holds before any new work is granted.
module fp32_addsub_arbiter
  import fp32_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int ADD_LATENCY = ADD_LATENCY_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_sub,
  input  logic                  hold,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  output logic                  add_valid,
  input  logic [31:0]           add_result,
  input  logic                  add_result_valid,
  output logic [31:0]           res_data,
  output logic [NUM_REQ-1:0]    res_valid,
  output logic                  busy,
  output logic                  err_tag
);

  localparam int CNT_W = $clog2(ADD_LATENCY + 1);

  logic [CNT_W-1:0]   drain_cnt_reg;
  logic               drain_active;
  logic               arb_en;
  logic               grant_valid;
  logic [ID_W-1:0]    grant_id;
  logic [NUM_REQ-1:0] grant;
  logic [31:0]        a_word [NUM_REQ];
  logic [31:0]        b_word [NUM_REQ];
  logic               add_valid_reg;
  logic [31:0]        add_a_reg;
  logic [31:0]        add_b_reg;
  logic [ID_W-1:0]    issue_id_reg;
  tag_t               tag_pipe [ADD_LATENCY];
  tag_t               tag_out;
  logic               tag_any;
  logic [NUM_REQ-1:0] owner_hot;
  logic [NUM_REQ-1:0] res_valid_reg;
  logic [31:0]        res_data_reg;
  logic               err_tag_reg;

  assign drain_active = (drain_cnt_reg != CNT_W'(ADD_LATENCY));

  // Drain counter: counts up once after reset and then parks at ADD_LATENCY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt_reg <= '0;
    end else if (drain_active) begin
      drain_cnt_reg <= drain_cnt_reg + 1'b1;
    end
  end

  assign arb_en = ~hold & ~drain_active;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (arb_en),
    .req         (req_valid),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign req_ready = grant;

  // Unpack the operand buses into per-requester words.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
      assign a_word[gi] = req_a[FP32_W*gi +: FP32_W];
      assign b_word[gi] = req_b[FP32_W*gi +: FP32_W];
    end
  endgenerate

  // Issue stage: register the granted operands; a/b keep their last values when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_valid_reg <= 1'b0;
      add_a_reg     <= '0;
      add_b_reg     <= '0;
      issue_id_reg  <= '0;
    end else begin
      add_valid_reg <= grant_valid;
      if (grant_valid) begin
        add_a_reg    <= a_word[grant_id];
        add_b_reg    <= flip_sign(b_word[grant_id], req_sub[grant_id]);
        issue_id_reg <= grant_id;
      end
    end
  end

  // Tag shift register: the last stage lines up with add_result_valid.
  generate
    for (genvar gi = 0; gi < ADD_LATENCY; gi++) begin : g_tag
      if (gi == 0) begin : g_first
        // First stage captures the op that is entering the adder this cycle.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            tag_pipe[gi] <= '0;
          end else begin
            tag_pipe[gi] <= '{valid: add_valid_reg, id: TAG_ID_W'(issue_id_reg)};
          end
        end
      end else begin : g_next
        // Later stages simply follow the adder pipeline.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            tag_pipe[gi] <= '0;
          end else begin
            tag_pipe[gi] <= tag_pipe[gi-1];
          end
        end
      end
    end
  endgenerate

  assign tag_out = tag_pipe[ADD_LATENCY-1];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_owner
      assign owner_hot[gi] = (tag_out.id == TAG_ID_W'(gi));
    end
  endgenerate

  // Result stage: one-cycle pulse to the owner, data broadcast and held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_reg <= '0;
      res_data_reg  <= '0;
    end else begin
      res_valid_reg <= tag_out.valid ? owner_hot : '0;
      if (tag_out.valid) begin
        res_data_reg <= add_result;
      end
    end
  end

  // Sticky error when the adder and our tag bookkeeping disagree after drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_tag_reg <= 1'b0;
    end else if (!drain_active && (add_result_valid != tag_out.valid)) begin
      err_tag_reg <= 1'b1;
    end
  end

  // Any op still travelling through the tag pipe keeps busy high.
  always_comb begin
    tag_any = 1'b0;
    for (int k = 0; k < ADD_LATENCY; k++) begin
      tag_any = tag_any | tag_pipe[k].valid;
    end
  end

  assign busy      = drain_active | tag_any | add_valid_reg | (|res_valid_reg);
  assign add_a     = add_a_reg;
  assign add_b     = add_b_reg;
  assign add_valid = add_valid_reg;
  assign res_data  = res_data_reg;
  assign res_valid = res_valid_reg;
  assign err_tag   = err_tag_reg;

endmodule

// File: tb/tb_fp32_addsub_arbiter.sv
// Bench for fp32_addsub_arbiter: a behavioural FP32 adder with fixed latency,
// a negedge monitor that predicts grants/results from the arbitration rules,
// a vector table for single ops and hand sequences for load, hold, reset and
// tag-error cases.
module tb_fp32_addsub_arbiter;
  import fp32_pkg::*;

  localparam int N = 4;
  localparam int IDW = 2;
  localparam int L = 11;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N-1:0]    req_sub;
  logic            hold;
  logic [31:0]     add_a;
  logic [31:0]     add_b;
  logic            add_valid;
  logic [31:0]     add_result;
  logic            add_result_valid;
  logic [31:0]     res_data;
  logic [N-1:0]    res_valid;
  logic            busy;
  logic            err_tag;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp32_addsub_arbiter #(.NUM_REQ(N), .ID_W(IDW), .ADD_LATENCY(L)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_a            (req_a),
    .req_b            (req_b),
    .req_sub          (req_sub),
    .hold             (hold),
    .add_a            (add_a),
    .add_b            (add_b),
    .add_valid        (add_valid),
    .add_result       (add_result),
    .add_result_valid (add_result_valid),
    .res_data         (res_data),
    .res_valid        (res_valid),
    .busy             (busy),
    .err_tag          (err_tag)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // FP32 <-> real for normal numbers and zero (enough for exact integer sums).
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    int e;
    if (f[30:23] == 8'h00) return 0.0;
    e = int'(f[30:23]) - 127 + 1023;
    d = {f[31], e[10:0], f[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Behavioural adder IP: fixed latency L, not reset, keeps emitting through reset.
  logic        apv [L];
  logic [31:0] apd [L];
  logic        a_init = 1'b0;
  logic        inj;

  always @(posedge clk) begin
    if (!a_init) begin
      for (int k = 0; k < L; k++) begin
        apv[k] <= 1'b0;
        apd[k] <= 32'h0;
      end
      a_init <= 1'b1;
    end else begin
      apv[0] <= add_valid;
      apd[0] <= r2f(f2r(add_a) + f2r(add_b));
      for (int k = 1; k < L; k++) begin
        apv[k] <= apv[k-1];
        apd[k] <= apd[k-1];
      end
    end
  end

  assign add_result_valid = apv[L-1] | inj;
  assign add_result       = apd[L-1];

  // Cycle count and cycles since reset release.
  int cyc = 0;
  int rel;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rel <= 0;
    else if (rel < L) rel <= rel + 1;
  end

  // Reference model state, consulted at every negedge.
  int          m_ptr = 0;
  int          exp_id [int];
  logic [31:0] exp_dat [int];
  logic [31:0] pend_a [int];
  logic [31:0] pend_b [int];
  logic        err_exp = 1'b0;

  initial begin : monitor
    int          x, eg, rid;
    bit          egv, drain_m, busy_m;
    logic [N-1:0] exp_rdy;
    logic [31:0] oa, ob;
    real         rv;
    forever begin
      @(negedge clk);
      x = cyc;
      if (!rst_n) begin
        exp_id.delete();
        exp_dat.delete();
        pend_a.delete();
        pend_b.delete();
        m_ptr = 0;
      end
      drain_m = !rst_n || (rel < L);
      // Expected owner: first valid requester from the rotation point, unless stalled.
      egv = 1'b0;
      eg = 0;
      if (!drain_m && !hold) begin
        for (int k = 0; k < N; k++) begin
          if (!egv && req_valid[(m_ptr + k) % N]) begin
            egv = 1'b1;
            eg = (m_ptr + k) % N;
          end
        end
      end
      exp_rdy = egv ? (N'(1) << eg) : '0;
      chk("req_ready", req_ready, exp_rdy);
      // busy from outstanding ops (issue cycle through result cycle) or drain.
      busy_m = drain_m;
      foreach (exp_id[r]) if (r - L - 1 <= x) busy_m = 1'b1;
      chk("busy", busy, busy_m);
      if (pend_a.exists(x)) begin
        chk("add_valid", add_valid, 1);
        chk("add_a", add_a, pend_a[x]);
        chk("add_b", add_b, pend_b[x]);
        pend_a.delete(x);
        pend_b.delete(x);
      end else begin
        chk("add_valid", add_valid, 0);
      end
      if (exp_id.exists(x)) begin
        rid = exp_id[x];
        chk("res_valid", res_valid, N'(1) << rid);
        chk("res_data", res_data, exp_dat[x]);
        $display("RES cyc=%0d req=%0d data=%08h exp=%08h", x, rid, res_data, exp_dat[x]);
        exp_id.delete(x);
        exp_dat.delete(x);
      end else begin
        chk("res_valid_idle", res_valid, 0);
      end
      chk("err_tag", err_tag, err_exp);
      if (egv) begin
        oa = req_a[32*eg +: 32];
        ob = req_b[32*eg +: 32];
        rv = req_sub[eg] ? f2r(oa) - f2r(ob) : f2r(oa) + f2r(ob);
        pend_a[x+1] = oa;
        pend_b[x+1] = r2f(req_sub[eg] ? -f2r(ob) : f2r(ob));
        exp_id[x+L+2] = eg;
        exp_dat[x+L+2] = r2f(rv);
        m_ptr = (eg + 1) % N;
      end
    end
  end

  task automatic rand_ops(input int i);
    req_a[32*i +: 32] = r2f(real'($urandom_range(1, 255)));
    req_b[32*i +: 32] = r2f(real'($urandom_range(1, 255)));
    req_sub[i] = 1'($urandom_range(0, 1));
  endtask

  // Random traffic; each requester holds its op until granted.
  task automatic run(input int ncyc, input int pct, input int hold_from, input int hold_len,
                     output int res_in_hold);
    logic [N-1:0] gr;
    res_in_hold = 0;
    for (int c = 0; c < ncyc; c++) begin
      hold = (c >= hold_from) && (c < hold_from + hold_len);
      @(negedge clk);
      gr = req_ready;
      if (hold) begin
        chk("hold_no_ready", gr, 0);
        if (res_valid != 0) res_in_hold++;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (gr[i] || !req_valid[i]) begin
          if (int'($urandom_range(0, 99)) < pct) begin
            rand_ops(i);
            req_valid[i] = 1'b1;
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
    end
    hold = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 100 && (busy || req_valid != 0)) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", n < 100, 1);
  endtask

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] exp_add_b;
    logic [31:0] exp_res;
  } vec_t;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs [5];
    int   n, dummy, first_g, last_g, cnt;
    bit   got;
    int   sent [N];
    int   glog [$];
    logic [N-1:0] gr;

    vecs[0] = '{0, FP32_ONE,     FP32_TWO,     1'b0, 32'h4000_0000, 32'h4040_0000};
    vecs[1] = '{2, FP32_ONE,     FP32_TWO,     1'b1, 32'hC000_0000, 32'hBF80_0000};
    vecs[2] = '{1, 32'h4040_0000, FP32_ONE,    1'b1, 32'hBF80_0000, 32'h4000_0000};
    vecs[3] = '{3, FP32_TWO,     FP32_TWO,     1'b0, 32'h4000_0000, 32'h4080_0000};
    vecs[4] = '{3, 32'hBF80_0000, 32'h4040_0000, 1'b1, 32'hC040_0000, 32'hC080_0000};

    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_sub = '0;
    hold = 1'b0;
    inj = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_add_valid", add_valid, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_err_tag", err_tag, 0);
    chk("rst_busy", busy, 1);
    rst_n = 1'b1;

    // Vector table: single ops with known results.
    for (int v = 0; v < 5; v++) begin
      req_a[32*vecs[v].id +: 32] = vecs[v].a;
      req_b[32*vecs[v].id +: 32] = vecs[v].b;
      req_sub[vecs[v].id] = vecs[v].sub;
      req_valid[vecs[v].id] = 1'b1;
      n = 0;
      got = 1'b0;
      while (n < 50 && !got) begin
        @(negedge clk);
        n++;
        if (req_ready[vecs[v].id]) got = 1'b1;
      end
      chk("vec_grant_seen", got, 1);
      if (v == 0) chk("drain_len", n, L + 1);
      @(posedge clk);
      #1;
      req_valid[vecs[v].id] = 1'b0;
      chk("vec_add_valid", add_valid, 1);
      chk("vec_add_b", add_b, vecs[v].exp_add_b);
      repeat (L + 1) @(posedge clk);
      #1;
      chk("vec_res_valid", res_valid, N'(1) << vecs[v].id);
      chk("vec_res_data", res_data, vecs[v].exp_res);
      chk("vec_busy_at_res", busy, 1);
      @(posedge clk);
      #1;
      chk("vec_busy_fall", busy, 0);
    end

    // Full load: all four requesters, 8 ops each, strict rotation without gaps.
    for (int i = 0; i < N; i++) begin
      rand_ops(i);
      req_valid[i] = 1'b1;
      sent[i] = 0;
    end
    first_g = -1;
    last_g = -1;
    for (int c = 0; c < 100 && req_valid != 0; c++) begin
      @(negedge clk);
      gr = req_ready;
      for (int i = 0; i < N; i++) begin
        if (gr[i]) begin
          glog.push_back(i);
          if (first_g < 0) first_g = c;
          last_g = c;
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (gr[i]) begin
          sent[i]++;
          if (sent[i] < 8) rand_ops(i);
          else req_valid[i] = 1'b0;
        end
      end
    end
    chk("rot_count", glog.size(), 32);
    for (int k = 0; k < glog.size(); k++) chk("rot_order", glog[k], k % N);
    chk("rot_no_gap", last_g - first_g + 1, 32);
    wait_idle();

    // hold for 5 cycles mid-stream.
    run(25, 100, 10, 5, cnt);
    chk("hold_results_seen", cnt > 0, 1);
    run(20, 0, -1, 0, dummy);
    wait_idle();

    // Reset with ops in flight while the adder keeps emitting.
    run(7, 100, -1, 0, dummy);
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < L; c++) begin
      @(negedge clk);
      if (req_ready != 0) cnt++;
    end
    chk("reset_drain_no_ready", cnt, 0);
    @(negedge clk);
    gr = req_ready;
    chk("reset_first_grant", gr != 0, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (gr[i]) req_valid[i] = 1'b0;
    run(20, 0, -1, 0, dummy);
    wait_idle();
    chk("reset_err_tag", err_tag, 0);

    // Spurious adder valid after drain sets the sticky error.
    @(posedge clk);
    #1;
    inj = 1'b1;
    @(posedge clk);
    #1;
    inj = 1'b0;
    err_exp = 1'b1;
    chk("err_set", err_tag, 1);
    run(10, 50, -1, 0, dummy);
    run(10, 0, -1, 0, dummy);
    wait_idle();
    chk("err_sticky", err_tag, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    err_exp = 1'b0;
    @(posedge clk);
    #1;
    chk("err_cleared", err_tag, 0);
    rst_n = 1'b1;
    repeat (L + 3) @(posedge clk);
    #1;
    chk("final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp32_addsub_arbiter.md
Name: fp32_addsub_arbiter

Overview:
- Shares one pipelined FP32 add/sub unit between NUM_REQ independent requesters. The unit is the existing addsub IP: a/b operands, sub flag, tvalid in, result plus tvalid out, fixed latency.
- Round-robin arbitration, one issue per cycle, with per-requester valid/ready on the operand side.
- A tag pipeline returns each result, as a one-cycle pulse, to the requester that issued it.
- Sits between the force/position-update datapath lanes and a single adder instance, to save DSP/LUT.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester-index width; must equal clog2(NUM_REQ).
- ADD_LATENCY, 11, adder pipeline depth in cycles from input tvalid to result tvalid (must match the IP configuration).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_a  in  NUM_REQ*32  packed operand A, requester i at [32*i+:32].
- req_b  in  NUM_REQ*32  packed operand B.
- req_sub  in  NUM_REQ  1 = A-B, 0 = A+B.
- hold  in  1  stall issue (no grants while high).
- add_a  out  32  to adder operand A.
- add_b  out  32  to adder operand B, sign already flipped when sub.
- add_valid  out  1  to adder s_axis tvalid (both A and B).
- add_result  in  32  from adder m_axis_result_tdata.
- add_result_valid  in  1  from adder m_axis_result_tvalid.
- res_data  out  32  result, broadcast to all requesters.
- res_valid  out  NUM_REQ  one-hot result-valid pulse to the owner.
- busy  out  1  any op in flight, or drain active.
- err_tag  out  1  sticky: adder valid and tag valid disagreed.

Behaviour:
- Reset values:
  - req_ready=0, add_valid=0, add_a=0, add_b=0, res_valid=0, res_data=0, err_tag=0.
  - busy=1 during drain.
  - Round-robin pointer=0, tag pipe cleared.
- Drain phase:
  - After rst_n deasserts, a counter runs ADD_LATENCY cycles.
  - No grants during drain. add_result_valid is ignored and is not checked, so stale IP contents are discarded.
  - busy stays 1 until the drain ends.
- Arbitration, combinational within the cycle:
  - grant = the first i with req_valid[i]=1, searching from ptr upward with wrap.
  - Suppressed when hold=1 or drain is active.
  - req_ready[i]=1 only for the granted i. ready may depend on valid.
  - Requesters must hold valid and data stable until ready.
- Issue register, one stage:
  - On grant, next cycle: add_valid=1, add_a=req_a[g], add_b={req_b[g][31]^req_sub[g], req_b[g][30:0]}.
  - Otherwise add_valid=0; a/b hold their last values.
- Pointer: after a grant to g, ptr=g+1 mod NUM_REQ. With no grant, ptr is unchanged.
- Tag pipeline:
  - ADD_LATENCY-stage shift of {valid, id}, loaded in step with add_valid.
  - The output stage aligns with add_result_valid.
- Result:
  - When the tag output is valid, in the next registered cycle: res_valid[id]=1 and res_data=add_result.
  - Total latency, grant cycle to res_valid, is ADD_LATENCY+2.
  - No result backpressure; requesters must accept.
- Mismatch: after drain, if add_result_valid != tag output valid, set err_tag (sticky until reset). The result is still delivered per the tag.
- busy: drain active, or any tag stage valid, or add_valid, or res_valid nonzero.
- Throughput: one op per cycle sustained. All requesters valid gives strict rotation 0,1,2,3,0…
- hold asserted mid-stream: in-flight ops complete normally; only new grants stop.
- Reset mid-operation: all in-flight ops are dropped with no res_valid, and a new drain starts.
- Simultaneous grant and result in the same cycle: independent paths, no conflict.

Decomposition:
- Shared package fp32_pkg:
  - FP32_W=32, FP32_SIGN_BIT=31.
  - ADD_LATENCY default.
  - Constants 1.0=0x3F800000, 2.0=0x40000000.
  - The tag struct {valid, id}.
- One natural sub-module: rr_arbiter (NUM_REQ req → one-hot grant, pointer update on grant), reusable for the multiplier sharer.

Test Plan:
- Single op: req0 a=0x3F800000, b=0x40000000, sub=0 → after ADD_LATENCY+2 cycles res_valid=0001 and res_data=0x40400000 (3.0); busy falls the next cycle.
- Subtract: req2 a=0x3F800000, b=0x40000000, sub=1 → add_b=0xC0000000, res_valid=0100, res_data=0xBF800000 (-1.0).
- All four requesters valid continuously for 8 ops each → grant order 0,1,2,3 repeating; 32 results, each to the correct owner; no gaps in add_valid.
- hold=1 for 5 cycles mid-stream → no req_ready during hold; pending results still arrive; rotation resumes from the saved ptr.
- rst_n pulsed low with 6 ops in flight, while the adder model keeps emitting → no res_valid for the stale ops; req_ready=0 for ADD_LATENCY cycles; err_tag stays 0.
- Adder model injects a spurious add_result_valid after drain → err_tag=1 and stays set until reset.
